// File: rtl/uartb_pkg.sv
// Shared constants and FSM state types for the uartb UART core.
package uartb_pkg;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned BYTES_PER_BURST = 4;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uartb_if.sv
// CPU-side register bus of the uartb core: write strobes, data and status.
interface uartb_if;

    logic [31:0] d;
    logic        wrtx;
    logic        wrbaud;
    logic        rd;
    logic [31:0] q;
    logic        dv;
    logic        ferr;
    logic        ovf;
    logic        thre;
    logic        tend;

    modport master (
        output d, wrtx, wrbaud, rd,
        input  q, dv, ferr, ovf, thre, tend
    );

    modport slave (
        input  d, wrtx, wrbaud, rd,
        output q, dv, ferr, ovf, thre, tend
    );

endinterface

// File: rtl/uartb_baud_tick.sv
// Bit-time down-counter: restart loads an arbitrary first interval, later intervals are div+1.
module uartb_baud_tick #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] load,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reloading from div on wrap makes divider changes take effect at a bit boundary.
    always_comb begin
        cnt_d = cnt_q - W'(1);
        if (restart) begin
            cnt_d = load;
        end else if (cnt_q == '0) begin
            cnt_d = div;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/uartb_core.sv
// Full-duplex 8N1 UART with programmable divider and 4-byte burst words.
module uartb_core
    import uartb_pkg::*;
#(
    parameter int unsigned DIV_W   = 9,
    parameter int unsigned DIV_RST = 7
) (
    input  logic     clk,
    input  logic     rst,
    uartb_if.slave   bus,
    input  logic     rxd,
    output logic     txd
);

    logic [DIV_W-1:0] div_q;
    logic             mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DIV_W'(DIV_RST);
            mode_q <= 1'b0;
        end else if (bus.wrbaud) begin
            div_q  <= bus.d[DIV_W-1:0];
            mode_q <= bus.d[31];
        end
    end

    // ---------------- transmitter ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [1:0]  tx_byte_q, tx_byte_d;
    logic [31:0] tx_sh_q, tx_sh_d;
    logic        tx_burst_q, tx_burst_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_mode_q, hold_mode_d;
    logic        hold_full_q, hold_full_d;
    logic        txd_q, txd_d;
    logic        tx_restart, tx_tick, load_sh;

    uartb_baud_tick #(.W(DIV_W)) u_tx_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (tx_restart),
        .load    (div_q),
        .div     (div_q),
        .tick    (tx_tick)
    );

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        tx_sh_d     = tx_sh_q;
        tx_burst_d  = tx_burst_q;
        hold_d      = hold_q;
        hold_mode_d = hold_mode_q;
        hold_full_d = hold_full_q;
        tx_restart  = 1'b0;
        load_sh     = 1'b0;
        txd_d       = 1'b1;

        unique case (tx_state_q)
            TxIdle: begin
                if (hold_full_q) begin
                    load_sh    = 1'b1;
                    tx_restart = 1'b1;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_tick) begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                end
            end
            TxData: begin
                if (tx_tick) begin
                    // Shifting the whole word brings the next burst byte into [7:0].
                    tx_sh_d = {1'b0, tx_sh_q[31:1]};
                    if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            TxStop: begin
                if (tx_tick) begin
                    if (tx_burst_q && tx_byte_q != 2'(BYTES_PER_BURST - 1)) begin
                        tx_byte_d  = tx_byte_q + 2'd1;
                        tx_state_d = TxStart;
                    end else if (hold_full_q) begin
                        load_sh    = 1'b1;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase

        if (load_sh) begin
            tx_sh_d     = hold_q;
            tx_burst_d  = hold_mode_q;
            tx_byte_d   = '0;
            hold_full_d = 1'b0;
        end else if (bus.wrtx && !hold_full_q) begin
            hold_d      = bus.d;
            hold_mode_d = mode_q;
            hold_full_d = 1'b1;
        end

        unique case (tx_state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = tx_sh_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TxIdle;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            tx_sh_q     <= '0;
            tx_burst_q  <= 1'b0;
            hold_q      <= '0;
            hold_mode_q <= 1'b0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            tx_sh_q     <= tx_sh_d;
            tx_burst_q  <= tx_burst_d;
            hold_q      <= hold_d;
            hold_mode_q <= hold_mode_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
        end
    end

    assign txd      = txd_q;
    assign bus.thre = !hold_full_q;
    assign bus.tend = (tx_state_q == TxIdle) && !hold_full_q;

    // ---------------- receiver ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [1:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_burst_q, rx_burst_d;
    logic [31:0] rx_buf_q, rx_buf_d;
    logic [31:0] q_q, q_d;
    logic        dv_q, dv_d, ovf_q, ovf_d, ferr_q, ferr_d;
    logic        rx_restart, rx_tick, word_done;

    uartb_baud_tick #(.W(DIV_W)) u_rx_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_restart),
        .load    (div_q >> 1),
        .div     (div_q),
        .tick    (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        rx_sh_d    = rx_sh_q;
        rx_burst_d = rx_burst_q;
        rx_buf_d   = rx_buf_q;
        q_d        = q_q;
        ferr_d     = ferr_q;
        rx_restart = 1'b0;
        word_done  = 1'b0;

        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_restart = 1'b1;
                    rx_state_d = RxStart;
                    if (rx_byte_q == '0) begin
                        rx_burst_d = mode_q;
                    end
                end
            end
            RxStart: begin
                if (rx_tick) begin
                    if (rx_s2_q) begin
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxData;
                        rx_bit_d   = '0;
                    end
                end
            end
            RxData: begin
                if (rx_tick) begin
                    rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'(DATA_BITS - 1)) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RxStop: begin
                if (rx_tick) begin
                    ferr_d     = !rx_s2_q;
                    rx_state_d = RxIdle;
                    if (!rx_burst_q) begin
                        q_d       = {24'b0, rx_sh_q};
                        word_done = 1'b1;
                    end else if (rx_byte_q == 2'(BYTES_PER_BURST - 1)) begin
                        q_d       = {rx_sh_q, rx_buf_q[23:0]};
                        word_done = 1'b1;
                        rx_byte_d = '0;
                    end else begin
                        rx_buf_d[{rx_byte_q, 3'b000} +: 8] = rx_sh_q;
                        rx_byte_d = rx_byte_q + 2'd1;
                    end
                end
            end
            default: rx_state_d = RxIdle;
        endcase

        // A read landing with a new word acknowledges the old one, so no overrun.
        dv_d  = word_done | (dv_q & !bus.rd);
        ovf_d = word_done ? (dv_q & !bus.rd) : (ovf_q & !bus.rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            rx_sh_q    <= '0;
            rx_burst_q <= 1'b0;
            rx_buf_q   <= '0;
            q_q        <= '0;
            dv_q       <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            rx_sh_q    <= rx_sh_d;
            rx_burst_q <= rx_burst_d;
            rx_buf_q   <= rx_buf_d;
            q_q        <= q_d;
            dv_q       <= dv_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.dv   = dv_q;
    assign bus.ovf  = ovf_q;
    assign bus.ferr = ferr_q;

endmodule

// File: tb/tb_uartb_core.sv
// Directed bench for uartb_core: pin-level TX, loopback RX, burst, overrun, errors, reset.
module tb_uartb_core;

    logic clk = 1'b0;
    logic rst;
    logic lb;
    logic rxd_drv;
    logic rxd;
    logic txd;
    int   checks = 0;
    int   failures = 0;

    uartb_if bus();

    assign rxd = lb ? txd : rxd_drv;

    uartb_core #(.DIV_W(9), .DIV_RST(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .rxd (rxd),
        .txd (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_tx(input logic [31:0] v);
        bus.d    = v;
        bus.wrtx = 1'b1;
        tick(1);
        bus.wrtx = 1'b0;
    endtask

    task automatic wr_baud(input logic [31:0] v);
        bus.d      = v;
        bus.wrbaud = 1'b1;
        tick(1);
        bus.wrbaud = 1'b0;
    endtask

    task automatic do_rd;
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
    endtask

    task automatic wait_dv(input string tag, input int budget);
        int i = 0;
        while (!bus.dv && i < budget) begin
            tick(1);
            i++;
        end
        check(tag, {31'b0, bus.dv}, 32'd1);
    endtask

    initial begin
        logic [9:0] frame_a;
        logic [9:0] bad;
        int i;
        frame_a    = 10'b1_0100_0001_0;
        bad        = {1'b0, 8'h55, 1'b0};
        rst        = 1'b1;
        lb         = 1'b0;
        rxd_drv    = 1'b1;
        bus.d      = '0;
        bus.wrtx   = 1'b0;
        bus.wrbaud = 1'b0;
        bus.rd     = 1'b0;
        tick(3);
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_thre", {31'b0, bus.thre}, 32'd1);
        check("rst_tend", {31'b0, bus.tend}, 32'd1);
        check("rst_dv", {31'b0, bus.dv}, 32'd0);
        check("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        check("rst_ferr", {31'b0, bus.ferr}, 32'd0);
        check("rst_q", bus.q, 32'h0);
        rst = 1'b0;
        tick(2);

        // Pin-level frame of 0x41, sampled mid-bit.
        wr_tx(32'h41);
        check("tx_thre_busy", {31'b0, bus.thre}, 32'd0);
        tick(1);
        check("tx_tend_busy", {31'b0, bus.tend}, 32'd0);
        tick(4);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), {31'b0, txd}, {31'b0, frame_a[k]});
            if (k < 9) tick(8);
        end
        tick(5);
        check("tx_tend_done", {31'b0, bus.tend}, 32'd1);

        // Normal-mode loopback.
        lb = 1'b1;
        wr_tx(32'h41);
        wait_dv("lb1_dv", 300);
        check("lb1_q", bus.q, 32'h41);
        check("lb1_ferr", {31'b0, bus.ferr}, 32'd0);
        do_rd;
        check("lb1_rd_dv", {31'b0, bus.dv}, 32'd0);
        tick(4);

        // Mode switch during 'B': 'B' still completes as a single frame.
        wr_tx(32'h42);
        tick(20);
        wr_baud(32'h8000_0007);
        wait_dv("lb2_dv", 300);
        check("lb2_q", bus.q, 32'h42);
        do_rd;
        tick(4);

        // Burst word: frames back-to-back, dv only after the fourth.
        wr_tx(32'h4443_4241);
        tick(84);
        check("burst_f1_start", {31'b0, txd}, 32'd0);
        tick(80);
        check("burst_f2_start", {31'b0, txd}, 32'd0);
        tick(80);
        check("burst_f3_start", {31'b0, txd}, 32'd0);
        tick(35);
        check("burst_dv_early", {31'b0, bus.dv}, 32'd0);
        wait_dv("burst_dv", 200);
        check("burst_q", bus.q, 32'h4443_4241);
        do_rd;
        tick(4);

        // Two words queued: no gap at the word boundary, second word overruns.
        wr_tx(32'h4443_4241);
        tick(5);
        wr_tx(32'h4948_4746);
        tick(319);
        check("b2b_w2_start", {31'b0, txd}, 32'd0);
        check("b2b_w1_dv", {31'b0, bus.dv}, 32'd1);
        check("b2b_w1_ovf", {31'b0, bus.ovf}, 32'd0);
        check("b2b_w1_q", bus.q, 32'h4443_4241);
        i = 0;
        while (!bus.ovf && i < 500) begin
            tick(1);
            i++;
        end
        check("b2b_ovf", {31'b0, bus.ovf}, 32'd1);
        check("b2b_q", bus.q, 32'h4948_4746);

        // Back to normal mode; rd clears both flags on the next edge.
        wr_baud(32'h7);
        do_rd;
        check("norm_rd_dv", {31'b0, bus.dv}, 32'd0);
        check("norm_rd_ovf", {31'b0, bus.ovf}, 32'd0);
        tick(100);
        wr_tx(32'h5A);
        wait_dv("norm_dv", 300);
        check("norm_q", bus.q, 32'h5A);
        check("norm_ovf", {31'b0, bus.ovf}, 32'd0);
        do_rd;
        check("norm_rd2_dv", {31'b0, bus.dv}, 32'd0);

        // Hand-driven frame with a zero stop bit.
        tick(100);
        lb = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rxd_drv = bad[k];
            tick(8);
        end
        rxd_drv = 1'b1;
        tick(4);
        check("ferr_set", {31'b0, bus.ferr}, 32'd1);
        check("ferr_q", bus.q, 32'h55);
        do_rd;
        tick(20);

        // A write while the holding register is full is dropped.
        lb = 1'b1;
        wr_tx(32'h11);
        tick(1);
        wr_tx(32'h22);
        check("hold_full_thre", {31'b0, bus.thre}, 32'd0);
        wr_tx(32'h33);
        wait_dv("drop_dv1", 300);
        check("drop_q1", bus.q, 32'h11);
        check("drop_ferr_clr", {31'b0, bus.ferr}, 32'd0);
        do_rd;
        wait_dv("drop_dv2", 300);
        check("drop_q2", bus.q, 32'h22);
        do_rd;
        tick(200);
        check("drop_no_third", {31'b0, bus.dv}, 32'd0);
        check("drop_tend", {31'b0, bus.tend}, 32'd1);

        // Reset in the middle of a frame with an unread word pending.
        wr_tx(32'h5A);
        wait_dv("mid_rst_pre_dv", 300);
        wr_tx(32'h5B);
        tick(30);
        rst = 1'b1;
        tick(1);
        check("mid_rst_txd", {31'b0, txd}, 32'd1);
        check("mid_rst_dv", {31'b0, bus.dv}, 32'd0);
        check("mid_rst_q", bus.q, 32'h0);
        check("mid_rst_thre", {31'b0, bus.thre}, 32'd1);
        rst = 1'b0;
        tick(200);
        check("mid_rst_discard", {31'b0, bus.dv}, 32'd0);
        check("mid_rst_tend", {31'b0, bus.tend}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uartb_core.md
Name: uartb_core

Overview:
- Full-duplex 8N1 UART core with programmable baud divider and a per-word "burst" mode.
- Normal mode: each TX write sends one byte, and each received byte is delivered as a word.
- Burst mode: each TX write sends a 32-bit word as 4 frames, LSB byte first. RX assembles 4 frames into one 32-bit word.
- Sits between a CPU register bus (write strobes, 32-bit data) and the serial pins.

Parameters:
- DIV_W, 9, width of the baud divider field (d[DIV_W-1:0]).
- DIV_RST, 7, divider value after reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- d  in  32  CPU write data: TX data on wrtx, config on wrbaud.
- wrtx  in  1  1-cycle strobe; load TX holding register.
- wrbaud  in  1  1-cycle strobe; load divider = d[DIV_W-1:0], mode = d[31].
- rd  in  1  1-cycle strobe; CPU has read q; clears dv and ovf.
- rxd  in  1  serial input, idle high (asynchronous to clk).
- txd  out  1  serial output, idle high.
- q  out  32  received word (normal mode: {24'b0, byte}).
- dv  out  1  received data valid.
- ferr  out  1  stop bit of the last received frame was 0.
- ovf  out  1  a word completed while dv was already 1.
- thre  out  1  TX holding register empty; a write is accepted.
- tend  out  1  transmitter fully idle: holding register and shifter empty.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - txd=1, thre=1, tend=1, dv=0, ovf=0, ferr=0, q=0.
  - divider=DIV_RST, mode=0.
  - TX and RX state machines go to IDLE.
- Bit time is (divider+1) clk cycles. A divider change applies from the next bit boundary of each FSM.
- Frame format: start(0), 8 data bits LSB first, stop(1). 10 bit times.
- Config write: wrbaud updates divider and mode on the same edge. mode is sampled only when a TX word is loaded and when an RX word starts. An in-flight word always completes in the mode it started in.
- TX holding register:
  - wrtx with thre=1: latch d (32 bits) plus the current mode; thre goes 0 on the next edge.
  - wrtx with thre=0: ignored.
- TX FSM states: IDLE, START, DATA(bit 0..7), STOP.
  - IDLE: if the holding register is full, move it to the shifter, set thre=1 and tend=0, then go to START. Latency is 1 clk from the wrtx edge to txd falling.
  - After STOP, in burst mode, bytes 1, 2, 3 follow back-to-back with no idle gap.
  - After the last byte's STOP: if the holding register is full, start the next word immediately. Otherwise go to IDLE with tend=1.
- RX:
  - rxd passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts a frame. The start bit is re-checked at half a bit time; if rxd=1 there, return to IDLE (glitch).
  - Data bits are sampled at mid-bit. The stop bit is sampled at mid-bit, and ferr is updated on every frame.
  - Normal mode: on the stop sample, q={24'b0, byte} and dv=1.
  - Burst mode: bytes are placed in q bytes 0..3 in order; q and dv update only after byte 3.
- A completed word while dv=1 overwrites q and sets ovf=1.
- rd clears dv and ovf on the next edge. If rd coincides with a word completion, dv=1 and ovf=0.
- Simultaneous wrbaud and wrtx on the same edge: the TX word latches the old mode.
- Reset mid-operation aborts both FSMs immediately: txd=1 on the next edge, and any partial RX word is discarded.

Decomposition:
- Shared package: frame constants (DATA_BITS=8, BYTES_PER_BURST=4) and the TX/RX FSM state enums.
- One sub-module is natural: uartb_baud_tick, a (divider+1) down-counter with restart and tick output. Instantiate it once each in the TX and RX paths.

Test Plan:
- Normal TX: divider=7, mode=0, wrtx d=0x41 -> txd shows 0,1,0,0,0,0,0,1,0,1, each 8 clk. tend=1 after 80 clk.
- Loopback txd->rxd, normal mode: send 0x41 then 0x42 -> dv pulses twice. q=0x00000041 then 0x00000042. ferr=0.
- Mode switch mid-frame: wrbaud d=0x80000007 during 'B' -> 'B' finishes as 1 frame. Then wrtx d=0x44434241 -> 4 contiguous frames 0x41, 0x42, 0x43, 0x44. Loopback q=0x44434241, dv=1 only after frame 4.
- Back-to-back bursts: second wrtx 0x49484746 while thre=1 during burst 1 -> 8 frames with no gap. With no rd in between, ovf=1 and q=0x49484746.
- Return to normal: wrbaud d=0x7, wrtx 0x5A -> single frame, q=0x0000005A. rd clears dv and ovf next cycle.
- Error and reset cases:
  - Force stop bit 0 on rxd -> ferr=1.
  - wrtx while thre=0 -> ignored.
  - rst mid-frame -> txd=1 and dv=0 next cycle.
